// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO built like an async FIFO: Gray-coded pointers cross to the
// opposite side through SYNC flop stages, so the full/empty flags are conservative
// with a fixed latency. Storage is distributed RAM with first-word-fall-through reads.
module gray_ptr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ABITS = 4,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wfull_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rempty_o
);

    localparam int unsigned Depth = 2 ** ABITS;

    logic [WIDTH-1:0] r_mem [Depth];

    logic [ABITS:0] r_wbin;
    logic [ABITS:0] r_wgray;
    logic [ABITS:0] r_rbin;
    logic [ABITS:0] r_rgray;
    logic [ABITS:0] r_wsync [SYNC];
    logic [ABITS:0] r_rsync [SYNC];
    logic           r_wfull;
    logic           r_rempty;

    logic           w_wr;
    logic           w_rd;
    logic [ABITS:0] w_wbin_next;
    logic [ABITS:0] w_wgray_next;
    logic [ABITS:0] w_rbin_next;
    logic [ABITS:0] w_rgray_next;
    logic [ABITS:0] w_wq;
    logic [ABITS:0] w_rq;

    function automatic logic [ABITS:0] bin2gray(input logic [ABITS:0] b);
        return b ^ (b >> 1);
    endfunction

    // Qualified strobes and next pointer values on both sides.
    always_comb begin
        w_wr         = wr_en_i & ~r_wfull;
        w_rd         = rd_en_i & ~r_rempty;
        w_wbin_next  = r_wbin + (ABITS + 1)'(w_wr);
        w_rbin_next  = r_rbin + (ABITS + 1)'(w_rd);
        w_wgray_next = bin2gray(w_wbin_next);
        w_rgray_next = bin2gray(w_rbin_next);
        w_wq         = r_wsync[SYNC-1];
        w_rq         = r_rsync[SYNC-1];
    end

    // Pointers, synchroniser pipelines and registered flags.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_rbin   <= '0;
            r_rgray  <= '0;
            r_wfull  <= 1'b0;
            r_rempty <= 1'b1;
            for (int i = 0; i < SYNC; i++) begin
                r_wsync[i] <= '0;
                r_rsync[i] <= '0;
            end
        end else begin
            r_wbin     <= w_wbin_next;
            r_wgray    <= w_wgray_next;
            r_rbin     <= w_rbin_next;
            r_rgray    <= w_rgray_next;
            r_wsync[0] <= r_wgray;
            r_rsync[0] <= r_rgray;
            for (int i = 1; i < SYNC; i++) begin
                r_wsync[i] <= r_wsync[i-1];
                r_rsync[i] <= r_rsync[i-1];
            end
            // Full when the write pointer is one lap ahead: top two Gray bits inverted.
            r_wfull  <= (w_wgray_next == {~w_rq[ABITS:ABITS-1], w_rq[ABITS-2:0]});
            r_rempty <= (w_rgray_next == w_wq);
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wbin[ABITS-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[r_rbin[ABITS-1:0]];
    assign wfull_o   = r_wfull;
    assign rempty_o  = r_rempty;

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Self-checking bench for gray_ptr_fifo. The reference model keeps a data queue plus
// running write/read counts; flags are derived from the counts as they stood SYNC+1
// edges earlier, which is what the synchronised comparison amounts to.
module tb_gray_ptr_fifo;

    localparam int unsigned W = 8;
    localparam int unsigned A = 4;
    localparam int unsigned S = 2;
    localparam int Depth = 2 ** A;

    logic         clk_i = 1'b0;
    logic         reset_ni = 1'b0;
    logic         wr_en_i = 1'b0;
    logic [W-1:0] wr_data_i = '0;
    logic         wfull_o;
    logic         rd_en_i = 1'b0;
    logic [W-1:0] rd_data_o;
    logic         rempty_o;

    gray_ptr_fifo #(
        .WIDTH(W),
        .ABITS(A),
        .SYNC (S)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_en_i  (wr_en_i),
        .wr_data_i(wr_data_i),
        .wfull_o  (wfull_o),
        .rd_en_i  (rd_en_i),
        .rd_data_o(rd_data_o),
        .rempty_o (rempty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [W-1:0] q[$];
    int           wcnt;
    int           rcnt;
    int           whist [S+2];
    int           rhist [S+2];
    logic         m_empty;
    logic         m_full;
    logic [W-1:0] last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt    = 0;
        rcnt    = 0;
        m_empty = 1'b1;
        m_full  = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            whist[i] = 0;
            rhist[i] = 0;
        end
    endtask

    // One clock: drive inputs, advance the model, then check flags and head data.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        logic acc_w;
        logic acc_r;
        wr_en_i   = w;
        wr_data_i = d;
        rd_en_i   = r;
        acc_w = w && !m_full;
        acc_r = r && !m_empty;
        if (acc_r) last_pop = rd_data_o;
        @(posedge clk_i);
        if (acc_r) void'(q.pop_front());
        if (acc_w) q.push_back(d);
        wcnt += int'(acc_w);
        rcnt += int'(acc_r);
        for (int i = S + 1; i > 0; i--) begin
            whist[i] = whist[i-1];
            rhist[i] = rhist[i-1];
        end
        whist[0] = wcnt;
        rhist[0] = rcnt;
        // The flag seen after edge t reflects the other side's count after edge t-(S+1).
        m_empty = (rcnt == whist[S+1]);
        m_full  = ((wcnt - rhist[S+1]) == Depth);
        #1;
        chk("rempty", 32'(rempty_o), 32'(m_empty));
        chk("wfull", 32'(wfull_o), 32'(m_full));
        if (!m_empty && q.size() > 0) chk("rd_data", 32'(rd_data_o), 32'(q[0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        last_pop = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_empty", 32'(rempty_o), 32'd1);
        chk("reset_full", 32'(wfull_o), 32'd0);
        reset_ni = 1'b1;

        // Reads while empty must be ignored.
        repeat (5) step(1'b0, '0, 1'b1);

        // Single word: empty falls after the third edge following the write.
        step(1'b1, 8'hA5, 1'b0);
        chk("a5_e0", 32'(rempty_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("a5_e1", 32'(rempty_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("a5_e2", 32'(rempty_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("a5_e3", 32'(rempty_o), 32'd0);
        chk("a5_data", 32'(rd_data_o), 32'hA5);
        step(1'b0, '0, 1'b1);
        chk("a5_pop_empty", 32'(rempty_o), 32'd1);
        repeat (4) step(1'b0, '0, 1'b0);

        // Fill to full, then a dropped 17th write.
        for (int i = 0; i < Depth; i++) step(1'b1, W'(i), 1'b0);
        chk("full_after_16", 32'(wfull_o), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        chk("full_drop", 32'(wfull_o), 32'd1);

        // One pop from full: full clears exactly three edges later.
        step(1'b0, '0, 1'b1);
        chk("pop_from_full_data", 32'(last_pop), 32'h00);
        chk("full_f0", 32'(wfull_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("full_f1", 32'(wfull_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("full_f2", 32'(wfull_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("full_f3", 32'(wfull_o), 32'd0);
        step(1'b1, 8'h10, 1'b0);
        for (int k = 0; k < 64 && q.size() > 0; k++) step(1'b0, '0, 1'b1);
        chk("drain_last", 32'(last_pop), 32'h10);
        chk("drain_empty", 32'(rempty_o), 32'd1);
        repeat (4) step(1'b0, '0, 1'b0);

        // Continuous simultaneous write/read over several pointer wraps.
        for (int i = 0; i < 100; i++) step(1'b1, W'(i), 1'b1);
        for (int k = 0; k < 64 && q.size() > 0; k++) step(1'b0, '0, 1'b1);
        chk("stream_last", 32'(last_pop), 32'd99);
        chk("stream_empty", 32'(rempty_o), 32'd1);

        // Random traffic with phases biased toward filling and toward draining.
        for (int i = 0; i < 600; i++) begin
            if ((i / 100) % 2 == 0) step(($urandom % 4) != 0, W'($urandom), ($urandom % 4) == 0);
            else step(($urandom % 4) == 0, W'($urandom), ($urandom % 4) != 0);
        end
        for (int k = 0; k < 64 && q.size() > 0; k++) step(1'b0, '0, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0);

        // Asynchronous reset mid-stream with seven words stored.
        for (int i = 0; i < 7; i++) step(1'b1, W'(8'h30 + i), 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        chk("pre_rst_empty", 32'(rempty_o), 32'd0);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("async_rst_empty", 32'(rempty_o), 32'd1);
        chk("async_rst_full", 32'(wfull_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
        for (int k = 0; k < 64 && q.size() > 0; k++) step(1'b0, '0, 1'b1);
        chk("post_rst_last", 32'(last_pop), 32'hC4);
        chk("post_rst_empty", 32'(rempty_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
